vga_write_arbiter: RTL and testbench

Shares the single VGA adapter pixel-write port (plot/X/Y/color) between the game's pixel producers: pillar animator, map drawer and sprite FSM. It replaces the combinational priority mux in the top level with a request/grant handshake.
- Burst locking keeps a producer's pixel stream unbroken.
- Bounded preemption lets a higher-priority producer interrupt a long burst.
- Output stage is registered and clips off-screen pixels.

---
 rtl/vga_write_arbiter_pkg.sv | 25 ++
 rtl/vga_write_arbiter_if.sv | 33 +++
 rtl/vga_write_arbiter_priority_pick.sv | 29 ++
 rtl/vga_write_arbiter.sv | 137 +++++++++++++
 tb/tb_vga_write_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_write_arbiter_pkg.sv
// Shared constants and types for the VGA pixel-write arbiter.
package vga_write_arbiter_pkg;

  localparam int REQ_ANIM   = 0;
  localparam int REQ_MAP    = 1;
  localparam int REQ_SPRITE = 2;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Counter must hold 0..max_burst; never narrower than one bit.
  function automatic int cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Producer-side request/pixel bus and the arbitrated VGA write port.
interface vga_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int X_W  = vga_write_arbiter_pkg::X_W,
  parameter int Y_W  = vga_write_arbiter_pkg::Y_W,
  parameter int C_W  = vga_write_arbiter_pkg::C_W
);
  import vga_write_arbiter_pkg::*;

  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     pix_valid;
  logic [NREQ*X_W-1:0] pix_x;
  logic [NREQ*Y_W-1:0] pix_y;
  logic [NREQ*C_W-1:0] pix_color;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     accept;
  logic                busy;
  logic                plot;
  logic [X_W-1:0]      X;
  logic [Y_W-1:0]      Y;
  logic [C_W-1:0]      color;

  modport master (
    output req, pix_valid, pix_x, pix_y, pix_color,
    input  gnt, accept, busy, plot, X, Y, color
  );

  modport slave (
    input  req, pix_valid, pix_x, pix_y, pix_color,
    output gnt, accept, busy, plot, X, Y, color
  );

endinterface

// File: rtl/vga_write_arbiter_priority_pick.sv
// Lowest-index-wins pick over (req & mask): one-hot, valid and encoded index.
module priority_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  output logic [NREQ-1:0]  gnt,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  import vga_write_arbiter_pkg::*;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    // Scan downward so the lowest set index is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && mask[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        valid  = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Burst-locked, boundedly-preemptible arbiter for the shared VGA pixel port,
// with a registered, screen-clipping output stage.
module vga_write_arbiter #(
  parameter int NREQ      = 3,
  parameter int X_W       = vga_write_arbiter_pkg::X_W,
  parameter int Y_W       = vga_write_arbiter_pkg::Y_W,
  parameter int C_W       = vga_write_arbiter_pkg::C_W,
  parameter int SCREEN_W  = vga_write_arbiter_pkg::SCREEN_W,
  parameter int SCREEN_H  = vga_write_arbiter_pkg::SCREEN_H,
  parameter int MAX_BURST = 64
) (
  input  logic               clock,
  input  logic               resetn,
  vga_write_arbiter_if.slave bus
);
  import vga_write_arbiter_pkg::*;

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [NREQ-1:0]  gnt_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             plot_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [C_W-1:0]   c_q;

  logic [NREQ-1:0]  accept;
  logic             own_acc, owner_req, reach_max, in_range;
  logic [X_W-1:0]   own_x;
  logic [Y_W-1:0]   own_y;
  logic [C_W-1:0]   own_c;

  logic [NREQ-1:0]  rel_mask, rel_gnt, pre_mask, pre_gnt;
  logic             rel_vld, pre_vld;
  logic [IDX_W-1:0] rel_idx, pre_idx;

  // gnt_q is one-hot (or zero), so any accept bit is the owner's.
  assign accept    = gnt_q & bus.pix_valid;
  assign own_acc   = |accept;
  assign owner_req = |(bus.req & gnt_q);

  assign own_x = bus.pix_x[32'(owner)*X_W +: X_W];
  assign own_y = bus.pix_y[32'(owner)*Y_W +: Y_W];
  assign own_c = bus.pix_color[32'(owner)*C_W +: C_W];
  assign in_range = (32'(own_x) < SCREEN_W) && (32'(own_y) < SCREEN_H);

  // Release candidates exclude the owner; preemption candidates are the
  // indices strictly below the owner (one-hot minus one).
  assign rel_mask = (state == IDLE) ? '1 : ~gnt_q;
  assign pre_mask = gnt_q - NREQ'(1);

  // Preempt once the accepted count, including this edge's pixel, reaches
  // the limit: the owner's next pixel is then held, not consumed.
  assign reach_max = (MAX_BURST != 0) &&
                     ((burst_cnt == CNT_MAX) ||
                      ((burst_cnt == CNT_MAX - CNT_W'(1)) && own_acc));

  priority_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rel_pick (
    .req(bus.req), .mask(rel_mask), .gnt(rel_gnt), .valid(rel_vld), .idx(rel_idx)
  );

  priority_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pre_pick (
    .req(bus.req), .mask(pre_mask), .gnt(pre_gnt), .valid(pre_vld), .idx(pre_idx)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= '0;
      gnt_q     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rel_vld) begin
            state     <= OWN;
            owner     <= rel_idx;
            gnt_q     <= rel_gnt;
            burst_cnt <= '0;
          end
        end
        OWN: begin
          if (!owner_req) begin
            burst_cnt <= '0;
            if (rel_vld) begin
              owner <= rel_idx;
              gnt_q <= rel_gnt;
            end else begin
              state <= IDLE;
              gnt_q <= '0;
            end
          end else if (reach_max && pre_vld) begin
            owner     <= pre_idx;
            gnt_q     <= pre_gnt;
            burst_cnt <= '0;
          end else if (own_acc && (burst_cnt != CNT_MAX)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Off-screen pixels are consumed but never strobed; coordinates hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
    end else begin
      plot_q <= own_acc && in_range;
      if (own_acc && in_range) begin
        x_q <= own_x;
        y_q <= own_y;
        c_q <= own_c;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.accept = accept;
  assign bus.busy   = (state == OWN);
  assign bus.plot   = plot_q;
  assign bus.X      = x_q;
  assign bus.Y      = y_q;
  assign bus.color  = c_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed vector table plus randomized run against a behavioural model.
module tb_vga_write_arbiter;
  import vga_write_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_write_arbiter_if #(.NREQ(NR)) bus();

  vga_write_arbiter #(.NREQ(NR), .MAX_BURST(MB)) dut (
    .clock(clk), .resetn(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [X_W-1:0] px[NR];
  logic [Y_W-1:0] py[NR];
  logic [C_W-1:0] pc[NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic [NR-1:0] valid);
    bus.req = req;
    bus.pix_valid = valid;
    for (int i = 0; i < NR; i++) begin
      bus.pix_x[i*X_W +: X_W] = px[i];
      bus.pix_y[i*Y_W +: Y_W] = py[i];
      bus.pix_color[i*C_W +: C_W] = pc[i];
    end
  endtask

  task automatic chk_out(input string tag, input logic [NR-1:0] g, input logic p,
                         input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                         input logic [C_W-1:0] c);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(|g));
    chk({tag, ".plot"}, 32'(bus.plot), 32'(p));
    chk({tag, ".X"}, 32'(bus.X), 32'(x));
    chk({tag, ".Y"}, 32'(bus.Y), 32'(y));
    chk({tag, ".color"}, 32'(bus.color), 32'(c));
  endtask

  // Slot 0 (animator) uses ax/ay/ac; slots 1 and 2 share x/y/c.
  typedef struct {
    logic [NR-1:0]  req, valid;
    logic [X_W-1:0] x, ax;
    logic [Y_W-1:0] y, ay;
    logic [C_W-1:0] c, ac;
    logic [NR-1:0]  eacc, egnt;
    logic           eplot;
    logic [X_W-1:0] ex;
    logic [Y_W-1:0] ey;
    logic [C_W-1:0] ec;
  } row_t;

  row_t rows[$];

  task automatic add(input logic [NR-1:0] req, valid, input int x, y, c, ax, ay, ac,
                     input logic [NR-1:0] eacc, egnt, input logic eplot,
                     input int ex, ey, ec);
    row_t r;
    r.req = req; r.valid = valid;
    r.x = X_W'(x); r.y = Y_W'(y); r.c = C_W'(c);
    r.ax = X_W'(ax); r.ay = Y_W'(ay); r.ac = C_W'(ac);
    r.eacc = eacc; r.egnt = egnt; r.eplot = eplot;
    r.ex = X_W'(ex); r.ey = Y_W'(ey); r.ec = C_W'(ec);
    rows.push_back(r);
  endtask

  // Lowest requesting index, skipping 'excl' and limited to indices < below.
  function automatic int lowest(input logic [NR-1:0] r, input int excl, input int below);
    for (int i = 0; i < NR; i++)
      if (r[i] && i != excl && i < below) return i;
    return -1;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m_owner, m_cnt, tot, hi;
    logic m_acc, m_plot;
    logic [X_W-1:0] m_x;
    logic [Y_W-1:0] m_y;
    logic [C_W-1:0] m_c;
    logic [NR-1:0] r_req, r_val, m_gnt;

    for (int i = 0; i < NR; i++) begin px[i] = '0; py[i] = '0; pc[i] = '0; end

    // Reset with every requester asking.
    drive(3'b111, 3'b000);
    repeat (2) @(negedge clk);
    chk_out("reset", 3'b000, 1'b0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("first_gnt", 3'b001, 1'b0, 0, 0, 0);
    drive(3'b000, 3'b000);
    @(negedge clk);
    chk_out("release_idle", 3'b000, 1'b0, 0, 0, 0);

    //   req     valid   x    y   c  ax  ay ac  eacc    egnt   plot ex  ey  ec
    add(3'b100, 3'b000,  0,   0, 0,  0, 0, 0, 3'b000, 3'b100, 0,   0,  0, 0);
    add(3'b100, 3'b100, 10,  20, 5,  0, 0, 0, 3'b100, 3'b100, 1,  10, 20, 5);
    add(3'b100, 3'b100, 11,  20, 5,  0, 0, 0, 3'b100, 3'b100, 1,  11, 20, 5);
    add(3'b100, 3'b100, 12,  20, 5,  0, 0, 0, 3'b100, 3'b100, 1,  12, 20, 5);
    add(3'b100, 3'b100, 13,  20, 5,  0, 0, 0, 3'b100, 3'b100, 1,  13, 20, 5);
    add(3'b100, 3'b000, 14,  20, 5,  0, 0, 0, 3'b000, 3'b100, 0,  13, 20, 5);
    add(3'b100, 3'b100, 320,  5, 2,  0, 0, 0, 3'b100, 3'b100, 0,  13, 20, 5);
    add(3'b100, 3'b100,  5, 240, 2,  0, 0, 0, 3'b100, 3'b100, 0,  13, 20, 5);
    add(3'b100, 3'b100, 319, 239, 7, 0, 0, 0, 3'b100, 3'b100, 1, 319, 239, 7);
    add(3'b000, 3'b100,  1,   1, 1,  0, 0, 0, 3'b100, 3'b000, 1,   1,  1, 1);
    add(3'b000, 3'b100,  2,   2, 2,  0, 0, 0, 3'b000, 3'b000, 0,   1,  1, 1);
    add(3'b110, 3'b000,  0,   0, 0,  0, 0, 0, 3'b000, 3'b010, 0,   1,  1, 1);
    add(3'b110, 3'b010, 50,  60, 3,  0, 0, 0, 3'b010, 3'b010, 1,  50, 60, 3);
    add(3'b100, 3'b000, 51,  60, 3,  0, 0, 0, 3'b000, 3'b100, 0,  50, 60, 3);
    add(3'b000, 3'b000,  0,   0, 0,  0, 0, 0, 3'b000, 3'b000, 0,  50, 60, 3);
    add(3'b010, 3'b000,  0,   0, 0,  0, 0, 0, 3'b000, 3'b010, 0,  50, 60, 3);
    add(3'b010, 3'b010, 100,  7, 4,  0, 0, 0, 3'b010, 3'b010, 1, 100,  7, 4);
    add(3'b011, 3'b010, 101,  7, 4,  0, 0, 0, 3'b010, 3'b010, 1, 101,  7, 4);
    add(3'b011, 3'b010, 102,  7, 4,  0, 0, 0, 3'b010, 3'b010, 1, 102,  7, 4);
    add(3'b011, 3'b010, 103,  7, 4,  0, 0, 0, 3'b010, 3'b001, 1, 103,  7, 4);
    add(3'b011, 3'b011, 104,  7, 4, 200, 9, 6, 3'b001, 3'b001, 1, 200, 9, 6);
    add(3'b010, 3'b010, 104,  7, 4,  0, 0, 0, 3'b000, 3'b010, 0, 200,  9, 6);
    add(3'b010, 3'b010, 104,  7, 4,  0, 0, 0, 3'b010, 3'b010, 1, 104,  7, 4);
    add(3'b000, 3'b000,  0,   0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 104,  7, 4);

    for (int k = 0; k < rows.size(); k++) begin
      @(negedge clk);
      if (k > 0)
        chk_out($sformatf("row%0d", k-1), rows[k-1].egnt, rows[k-1].eplot,
                rows[k-1].ex, rows[k-1].ey, rows[k-1].ec);
      px[0] = rows[k].ax; py[0] = rows[k].ay; pc[0] = rows[k].ac;
      for (int i = 1; i < NR; i++) begin px[i] = rows[k].x; py[i] = rows[k].y; pc[i] = rows[k].c; end
      drive(rows[k].req, rows[k].valid);
      #1 chk($sformatf("row%0d.accept", k), 32'(bus.accept), 32'(rows[k].eacc));
    end
    @(negedge clk);
    chk_out("row_last", rows[rows.size()-1].egnt, rows[rows.size()-1].eplot,
            rows[rows.size()-1].ex, rows[rows.size()-1].ey, rows[rows.size()-1].ec);

    // Reset in the middle of a sprite burst acts without a clock edge.
    px[2] = 30; py[2] = 40; pc[2] = 1;
    drive(3'b100, 3'b000);
    @(negedge clk);
    chk("midrst.gnt", 32'(bus.gnt), 32'(3'b100));
    drive(3'b100, 3'b100);
    @(negedge clk);
    chk("midrst.plot_pre", 32'(bus.plot), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk_out("midrst.async", 3'b000, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst.acc_nogrant", 32'(bus.accept), 32'(3'b000));
    @(negedge clk);
    chk_out("midrst.regrant", 3'b100, 1'b0, 0, 0, 0);
    #1 chk("midrst.acc", 32'(bus.accept), 32'(3'b100));
    @(negedge clk);
    chk_out("midrst.plot", 3'b100, 1'b1, 30, 40, 1);

    // Randomized traffic against the model, starting from a fresh reset.
    drive(3'b000, 3'b000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_owner = -1; m_cnt = 0; m_plot = 1'b0; m_x = '0; m_y = '0; m_c = '0;
    r_req = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 7) == 0) r_req[i] = ~r_req[i];
        r_val[i] = ($urandom_range(0, 3) != 0);
        px[i] = X_W'($urandom_range(0, 340));
        py[i] = Y_W'($urandom_range(0, 250));
        pc[i] = C_W'($urandom);
      end
      drive(r_req, r_val);
      m_gnt = (m_owner < 0) ? '0 : NR'(1 << m_owner);
      #1 chk($sformatf("rnd%0d.accept", n), 32'(bus.accept), 32'(m_gnt & r_val));

      m_acc = (m_owner >= 0) && r_val[m_owner];
      m_plot = 1'b0;
      if (m_acc && int'(px[m_owner]) < SCREEN_W && int'(py[m_owner]) < SCREEN_H) begin
        m_plot = 1'b1;
        m_x = px[m_owner]; m_y = py[m_owner]; m_c = pc[m_owner];
      end
      if (m_owner < 0) begin
        m_owner = lowest(r_req, -1, NR);
        m_cnt = 0;
      end else if (!r_req[m_owner]) begin
        m_owner = lowest(r_req, m_owner, NR);
        m_cnt = 0;
      end else begin
        tot = m_cnt + int'(m_acc);
        hi = lowest(r_req, -1, m_owner);
        if (tot >= MB && hi >= 0) begin
          m_owner = hi;
          m_cnt = 0;
        end else begin
          m_cnt = (tot > MB) ? MB : tot;
        end
      end

      @(negedge clk);
      m_gnt = (m_owner < 0) ? '0 : NR'(1 << m_owner);
      chk_out($sformatf("rnd%0d", n), m_gnt, m_plot, m_x, m_y, m_c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
